// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 8-digit seven-segment scanner.
package seg_pkg;
    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    localparam int         NUM_DIG   = 8;
    localparam logic [7:0] BLANK_PAT = 8'hFF;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  en;
    } disp_t;
endpackage

// File: rtl/decoder_7_seg.sv
// Registered hex-to-seven-segment decoder, active-low, seg[6]=CA .. seg[0]=CG.
module decoder_7_seg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 7'h7F;
        end else begin
            case (hex)
                4'h0: seg <= 7'h01;
                4'h1: seg <= 7'h4F;
                4'h2: seg <= 7'h12;
                4'h3: seg <= 7'h06;
                4'h4: seg <= 7'h4C;
                4'h5: seg <= 7'h24;
                4'h6: seg <= 7'h20;
                4'h7: seg <= 7'h0F;
                4'h8: seg <= 7'h00;
                4'h9: seg <= 7'h04;
                4'hA: seg <= 7'h08;
                4'hB: seg <= 7'h60;
                4'hC: seg <= 7'h31;
                4'hD: seg <= 7'h42;
                4'hE: seg <= 7'h30;
                default: seg <= 7'h38;
            endcase
        end
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit display scanner with blanking gaps and a
// frame-synchronous double-buffered load of data / decimal points / enables.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int ON_CYC    = 99984,
    parameter int BLANK_CYC = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] DATA,
    input  logic [7:0]  DP_IN,
    input  logic [7:0]  DIG_EN,
    input  logic        LOAD,
    output logic        READY,
    output logic [7:0]  AN,
    output logic [7:0]  SEG,
    output logic        FRAME
);
    localparam int MAXC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    dig;
    logic          slot_end, wrap;
    logic          ready_q, frame_q, dp_q;
    disp_t         act, shd;
    logic [6:0]    dec_seg;

    assign slot_end = (state == SHOW) ? (cnt == ON_LAST) : (cnt == BLANK_LAST);
    assign wrap     = (state == SHOW) && slot_end && (dig == 3'(NUM_DIG - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= BLANK;
        else        state <= nxt;
    end

    always_comb begin
        nxt = BLANK;
        case (state)
            BLANK:   nxt = slot_end ? SHOW : BLANK;
            SHOW:    nxt = slot_end ? BLANK : SHOW;
            default: nxt = BLANK;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= '0;
            dig     <= '0;
            frame_q <= 1'b0;
            dp_q    <= 1'b1;
        end else begin
            cnt     <= slot_end ? '0 : cnt + CW'(1);
            if (state == SHOW && slot_end) dig <= dig + 3'd1;
            frame_q <= wrap;
            dp_q    <= ~act.dp[dig];
        end
    end

    // Shadow is only promoted at the frame wrap so a frame never mixes old and new data.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            act     <= '0;
            shd     <= '0;
            ready_q <= 1'b1;
        end else if (wrap && !ready_q) begin
            act     <= shd;
            ready_q <= 1'b1;
        end else if (LOAD && ready_q) begin
            shd     <= '{data: DATA, dp: DP_IN, en: DIG_EN};
            ready_q <= 1'b0;
        end
    end

    // The current digit's nibble is fed all through BLANK, so the registered
    // decoder has settled before the anode turns on.
    decoder_7_seg u_dec (
        .clk  (CLK),
        .rst_n(RST_N),
        .hex  (act.data[{dig, 2'b00} +: 4]),
        .seg  (dec_seg)
    );

    always_comb begin
        AN  = BLANK_PAT;
        SEG = BLANK_PAT;
        if (state == SHOW) begin
            SEG = {dec_seg, dp_q};
            if (act.en[dig]) AN = ~(8'd1 << dig);
        end
    end

    assign READY = ready_q;
    assign FRAME = frame_q;
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter ON_CYC, default 99984, meaning cycles each digit's anode is driven.
REQ-002 SHALL have parameter BLANK_CYC, default 16, meaning all-anodes-off cycles before each digit (legal range 2..255).
REQ-003 SHALL have port CLK, input, 1, the single system clock.
REQ-004 SHALL have port RST_N, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port DATA, input, 32, with nibble k shown on digit k (digit 0 rightmost).
REQ-006 SHALL have port DP_IN, input, 8, the per-digit decimal point (1 = lit).
REQ-007 SHALL have port DIG_EN, input, 8, the per-digit enable (1 = digit shown).
REQ-008 SHALL have port LOAD, input, 1, a request to capture DATA/DP_IN/DIG_EN.
REQ-009 SHALL have port READY, output, 1, meaning shadow registers are free and LOAD will be accepted.
REQ-010 SHALL have port AN, output, 8, the active-low anodes.
REQ-011 SHALL have port SEG, output, 8, the active-low segments with bit7=CA through bit1=CG and bit0=DP.
REQ-012 SHALL have port FRAME, output, 1, a one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL scan digits 0..7 in order, each slot being BLANK_CYC cycles in state BLANK then ON_CYC cycles in state SHOW, and wrap 7->0.
REQ-014 SHALL drive AN=8'hFF throughout BLANK.
REQ-015 SHALL drive AN[k] low alone during SHOW of digit k when active enable bit k=1, and keep AN=8'hFF when that bit=0, with slot timing unchanged.
REQ-016 SHALL present active nibble k to the registered decoder (1-cycle latency) for all of BLANK for digit k, so SEG is stable for the whole SHOW.
REQ-017 SHALL force SEG[0] to the inverse of active DP bit k, registered in the same cycle as the decoder output.
REQ-018 SHALL hold SEG at 8'hFF in BLANK cycles until the decoder output for the new digit is valid, never showing the previous digit's pattern under a new anode.
REQ-019 SHALL, on LOAD with READY=1, capture DATA/DP_IN/DIG_EN into shadow registers and drive READY low the next cycle.
REQ-020 SHALL ignore LOAD with READY=0, with no shadow change.
REQ-021 SHALL define the frame boundary as the first BLANK cycle of digit 0, and pulse FRAME high for exactly that cycle.
REQ-022 SHALL, at a frame boundary with READY=0, copy shadow to active and raise READY that cycle.
REQ-023 SHALL, on LOAD at a frame-boundary cycle with READY=1, capture it and apply it at the following boundary, never in the same cycle.
REQ-024 SHALL size the slot counter ceil(log2(max(ON_CYC,BLANK_CYC))) bits, compare terminal count against the parameter minus 1, and allow no intermediate overflow.
REQ-025 SHALL have exactly two states, BLANK and SHOW, with no unreachable encodings; illegal encodings go to BLANK.

Reset
REQ-026 SHALL, on RST_N low, immediately and asynchronously set AN=8'hFF, SEG=8'hFF, READY=1, FRAME=0, digit=0, state=BLANK, counter=0, and active/shadow registers=0 (display dark).
REQ-027 SHALL discard a pending shadow load on reset asserted mid-frame.
REQ-028 SHALL start the first slot on the first clock after RST_N release, with no FRAME pulse in that cycle.

Structure
REQ-029 SHALL keep the state encoding (BLANK, SHOW), digit count 8, and the blank pattern 8'hFF in a shared package seg_pkg.
REQ-030 SHALL instantiate the existing registered hex decoder decoder_7_seg as its single sub-module, with no duplicated decode table.

Verification (ON_CYC=8, BLANK_CYC=4)
REQ-031 SHALL verify that LOAD DATA=32'h76543210, DIG_EN=FF, DP_IN=00 gives AN sequence FE,FD,..,7F, each low 8 cycles after 4 blank cycles, with SEG 03,9F,25,0D,99,49,41,1F per digit.
REQ-032 SHALL verify that DIG_EN=8'h0F leaves AN[7:4] high forever while the frame period stays 96 cycles and FRAME pulses every 96 cycles.
REQ-033 SHALL verify that DP_IN=8'h01 with DATA nibble0=8 gives SEG=8'h00 on digit 0 and SEG[0]=1 on other digits.
REQ-034 SHALL verify that a second LOAD while READY=0 is ignored, and that the first load appears only at the next FRAME, when READY rises.
REQ-035 SHALL verify that LOAD coinciding with FRAME is applied one frame later, not at the same boundary.
REQ-036 SHALL verify that RST_N pulled low mid-SHOW of digit 3 immediately gives AN=FF, SEG=FF, READY=1, and that the scan restarts at digit 0 after release.
